acq_search_ctrl: RTL and testbench

// Acquisition search scheduler for the GPS correlator top. Sweeps PRN and Doppler bins and

---
 rtl/acq_search_ctrl.sv | 177 +++++++++++++++++
 tb/tb_acq_search_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/acq_search_ctrl.sv
// Acquisition search scheduler for the GPS correlator.
// Steps through PRN x Doppler bins. For each bin it configures the correlator,
// lets the configuration settle, clears the accumulators and waits one dwell.
// It then samples the correlator peak and keeps the strongest one seen.
// At the end it reports best_* and a found flag, computed against the threshold
// that was latched at start.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; results of the last sweep are held
// CONFIG  | drive PRN / doppler_tw for the current bin
// SETTLE  | let the correlator front end settle on the new config
// CLEAR   | one-cycle corr_clr pulse
// DWELL   | accumulate for DWELL_CYC cycles
// CAPTURE | compare accum_max against best, advance the bin
// DONE    | one-cycle done pulse, found valid
module acq_search_ctrl #(
    parameter int          PRN_FIRST    = 1,
    parameter int          PRN_LAST     = 32,
    parameter int          DOPP_BINS    = 21,
    parameter logic [31:0] DOPP_CTR_TW  = 32'd4294967,
    parameter logic [31:0] DOPP_STEP_TW = 32'd134218,
    parameter int          SETTLE_CYC   = 16,
    parameter int          DWELL_CYC    = 16000,
    parameter int          ACC_W        = 32,
    parameter int          ID_W         = 10
) (
    input  logic             CLK_16M,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [ACC_W-1:0] threshold,
    input  logic [ACC_W-1:0] accum_max,
    input  logic [ID_W-1:0]  max_ID,
    output logic [4:0]       PRN,
    output logic [31:0]      doppler_tw,
    output logic             corr_clr,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [4:0]       best_prn,
    output logic [31:0]      best_tw,
    output logic [ID_W-1:0]  best_phase,
    output logic [ACC_W-1:0] best_mag
);

    localparam int          HALF    = (DOPP_BINS - 1) / 2;
    // Tuning word of bin 0. The arithmetic is done modulo 2^32, so the value
    // wraps when the centre is closer to zero than the half span.
    localparam logic [31:0] TW_LO   = DOPP_CTR_TW - 32'(HALF) * DOPP_STEP_TW;
    localparam int          TMR_MAX = (DWELL_CYC > SETTLE_CYC) ? DWELL_CYC : SETTLE_CYC;
    localparam int          TMR_W   = $clog2(TMR_MAX + 1);
    localparam int          K_W     = (DOPP_BINS > 1) ? $clog2(DOPP_BINS) : 1;

    typedef enum logic [2:0] {
        IDLE, CONFIG, SETTLE, CLEAR, DWELL, CAPTURE, DONE
    } state_t;

    state_t             state, nxt;
    logic [TMR_W-1:0]   tmr;
    logic [K_W-1:0]     k;
    // One bit wider than the PRN bus so that PRN 32 can be compared as the
    // last PRN. On the 5-bit bus, PRN 32 appears as 5'd0.
    logic [5:0]         prn_idx;
    logic [31:0]        tw_acc;
    logic [ACC_W-1:0]   thr_q;

    logic start_ok, last_bin, last_prn, cap_upd, tmr_tc;

    assign start_ok = (state == IDLE) && start && !abort;
    assign last_bin = (k == K_W'(DOPP_BINS - 1));
    assign last_prn = (prn_idx == 6'(PRN_LAST));
    assign tmr_tc   = (tmr == '0);
    assign cap_upd  = (state == CAPTURE) && !abort && (accum_max > best_mag);

    // State register
    always_ff @(posedge CLK_16M or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state and pulse/status outputs; abort overrides any transition
    always_comb begin
        nxt      = state;
        corr_clr = 1'b0;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE:    if (start_ok) nxt = CONFIG;
            CONFIG:  nxt = SETTLE;
            SETTLE:  if (tmr_tc) nxt = CLEAR;
            CLEAR: begin
                corr_clr = 1'b1;
                nxt      = DWELL;
            end
            DWELL:   if (tmr_tc) nxt = CAPTURE;
            CAPTURE: nxt = (last_bin && last_prn) ? DONE : CONFIG;
            DONE: begin
                done = !abort;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE) nxt = IDLE;
    end

    // Settle/dwell down-counter, loaded on entry and stopping at terminal count
    always_ff @(posedge CLK_16M or posedge RST) begin
        if (RST) begin
            tmr <= '0;
        end else begin
            case (state)
                CONFIG:         tmr <= TMR_W'(SETTLE_CYC - 1);
                CLEAR:          tmr <= TMR_W'(DWELL_CYC - 1);
                SETTLE, DWELL:  if (!tmr_tc) tmr <= tmr - 1'b1;
                default:        tmr <= tmr;
            endcase
        end
    end

    // Sweep indices, correlator configuration, peak tracking and result flags
    always_ff @(posedge CLK_16M or posedge RST) begin
        if (RST) begin
            thr_q      <= '0;
            prn_idx    <= 6'(PRN_FIRST);
            k          <= '0;
            tw_acc     <= TW_LO;
            PRN        <= 5'(PRN_FIRST);
            doppler_tw <= DOPP_CTR_TW;
            found      <= 1'b0;
            best_prn   <= '0;
            best_tw    <= '0;
            best_phase <= '0;
            best_mag   <= '0;
        end else if (start_ok) begin
            thr_q      <= threshold;
            prn_idx    <= 6'(PRN_FIRST);
            k          <= '0;
            tw_acc     <= TW_LO;
            found      <= 1'b0;
            best_prn   <= '0;
            best_tw    <= '0;
            best_phase <= '0;
            best_mag   <= '0;
        end else if (abort && state != IDLE) begin
            found <= 1'b0;
        end else begin
            case (state)
                CONFIG: begin
                    PRN        <= prn_idx[4:0];
                    doppler_tw <= tw_acc;
                end
                CAPTURE: begin
                    if (cap_upd) begin
                        best_mag   <= accum_max;
                        best_prn   <= PRN;
                        best_tw    <= doppler_tw;
                        best_phase <= max_ID;
                    end
                    if (last_bin) begin
                        k       <= '0;
                        tw_acc  <= TW_LO;
                        prn_idx <= prn_idx + 1'b1;
                    end else begin
                        k      <= k + 1'b1;
                        tw_acc <= tw_acc + DOPP_STEP_TW;
                    end
                    // The final capture may still raise best_mag on this edge.
                    if (last_bin && last_prn)
                        found <= ((cap_upd ? accum_max : best_mag) > thr_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Directed bench for acq_search_ctrl. It uses a small 2-PRN x 3-bin sweep
// (period 10 cycles) with a stub correlator, plus a second instance whose
// centre tuning word is 0 to exercise wrap-around.
module tb_acq_search_ctrl;

    localparam logic [31:0] CTR  = 32'd4294967;
    localparam logic [31:0] STEP = 32'd134218;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, abort = 1'b0;
    logic [31:0] threshold = '0;
    logic [31:0] accum_max;
    logic [9:0]  max_ID;
    logic [4:0]  prn, best_prn;
    logic [31:0] doppler_tw, best_tw, best_mag;
    logic [9:0]  best_phase;
    logic        corr_clr, busy, done, found;

    logic        start_w = 1'b0, abort_w = 1'b0;
    logic [31:0] thr_w = '0, acc_w = '0;
    logic [9:0]  id_w = '0;
    logic [4:0]  prn_w, best_prn_w;
    logic [31:0] tw_w, best_tw_w, best_mag_w;
    logic [9:0]  best_phase_w;
    logic        clr_w, busy_w, done_w, found_w;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;

    acq_search_ctrl #(.PRN_FIRST(3), .PRN_LAST(4), .DOPP_BINS(3), .DOPP_CTR_TW(CTR),
                      .DOPP_STEP_TW(STEP), .SETTLE_CYC(2), .DWELL_CYC(5),
                      .ACC_W(32), .ID_W(10)) dut (
        .CLK_16M(clk), .RST(rst), .start(start), .abort(abort), .threshold(threshold),
        .accum_max(accum_max), .max_ID(max_ID), .PRN(prn), .doppler_tw(doppler_tw),
        .corr_clr(corr_clr), .busy(busy), .done(done), .found(found),
        .best_prn(best_prn), .best_tw(best_tw), .best_phase(best_phase), .best_mag(best_mag));

    acq_search_ctrl #(.PRN_FIRST(1), .PRN_LAST(1), .DOPP_BINS(3), .DOPP_CTR_TW(32'd0),
                      .DOPP_STEP_TW(STEP), .SETTLE_CYC(2), .DWELL_CYC(5),
                      .ACC_W(32), .ID_W(10)) dut_w (
        .CLK_16M(clk), .RST(rst), .start(start_w), .abort(abort_w), .threshold(thr_w),
        .accum_max(acc_w), .max_ID(id_w), .PRN(prn_w), .doppler_tw(tw_w),
        .corr_clr(clr_w), .busy(busy_w), .done(done_w), .found(found_w),
        .best_prn(best_prn_w), .best_tw(best_tw_w), .best_phase(best_phase_w),
        .best_mag(best_mag_w));

    // Stub correlator. Mode 0: 100 everywhere, except 500 at PRN 4 on the upper bin;
    // phase 8. Mode 1: 300 everywhere; phase = PRN*4 + bin, so the bin that won is visible.
    always_comb begin
        logic [1:0] bidx;
        bidx = (doppler_tw == CTR - STEP) ? 2'd0 : (doppler_tw == CTR) ? 2'd1 : 2'd2;
        if (mode == 0) begin
            accum_max = (prn == 5'd4 && doppler_tw == CTR + STEP) ? 32'd500 : 32'd100;
            max_ID    = 10'd8;
        end else begin
            accum_max = 32'd300;
            max_ID    = 10'({prn, 2'b00}) + 10'(bidx);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start, then follow the sweep until done. Returns the cycle of done
    // (the first CONFIG cycle is 1) and the number of corr_clr pulses. A second
    // start is pulsed at cycle extra_start when extra_start > 0.
    task automatic run_sweep(input int extra_start, output int cyc, output int clrs);
        bit seen;
        seen = 0; clrs = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (!seen && cyc < 2000) begin
            if (corr_clr) clrs++;
            if (done) seen = 1;
            else begin
                if (cyc == extra_start) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
        end
        chk("sweep_done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        int cyc, clrs, cnt;
        bit bad;
        logic [31:0] tws[3];

        // Reset values
        #500;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr", corr_clr, 0);
        chk("rst_found", found, 0);
        chk("rst_prn", prn, 3);
        chk("rst_tw", doppler_tw, CTR);
        chk("rst_best_prn", best_prn, 0);
        chk("rst_best_tw", best_tw, 0);
        chk("rst_best_phase", best_phase, 0);
        chk("rst_best_mag", best_mag, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Strong peak at PRN 4, upper bin; extra start while busy must be ignored
        mode = 0; threshold = 32'd200;
        run_sweep(30, cyc, clrs);
        chk("t2_cycles", cyc, 61);
        chk("t2_clr_count", clrs, 6);
        chk("t2_found", found, 1);
        chk("t2_best_prn", best_prn, 4);
        chk("t2_best_tw", best_tw, CTR + STEP);
        chk("t2_best_phase", best_phase, 8);
        chk("t2_best_mag", best_mag, 500);
        chk("t2_prn_hold", prn, 4);
        chk("t2_tw_hold", doppler_tw, CTR + STEP);
        @(negedge clk);
        chk("t2_done_pulse", done, 0);
        chk("t2_busy_after", busy, 0);
        chk("t2_found_hold", found, 1);

        // All-equal peaks: first bin wins, strict threshold compare
        mode = 1; threshold = 32'd300;
        run_sweep(0, cyc, clrs);
        chk("t4_cycles", cyc, 61);
        chk("t4_found", found, 0);
        chk("t4_best_prn", best_prn, 3);
        chk("t4_best_tw", best_tw, CTR - STEP);
        chk("t4_best_phase", best_phase, 12);
        chk("t4_best_mag", best_mag, 300);

        // Abort in DWELL of the second bin
        mode = 0; threshold = 32'd200;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) bad = 1;
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("t5_busy", busy, 0);
        cnt = 0;
        repeat (40) begin
            if (done) bad = 1;
            if (corr_clr) cnt++;
            @(negedge clk);
        end
        chk("t5_no_done", 64'(bad), 0);
        chk("t5_no_clr", cnt, 0);
        chk("t5_found", found, 0);
        chk("t5_best_mag", best_mag, 100);
        chk("t5_best_prn", best_prn, 3);
        chk("t5_best_tw", best_tw, CTR - STEP);
        run_sweep(0, cyc, clrs);
        chk("t5_rerun_cycles", cyc, 61);
        chk("t5_rerun_clr", clrs, 6);
        chk("t5_rerun_found", found, 1);

        // start together with abort in IDLE is dropped
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("t6_busy", busy, 0);
        cnt = 0;
        repeat (20) begin
            if (corr_clr || busy) cnt++;
            @(negedge clk);
        end
        chk("t6_idle", cnt, 0);
        chk("t6_found_hold", found, 1);

        // Tuning-word wrap with a zero centre
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        cyc = 1; cnt = 0;
        while (!done_w && cyc < 200) begin
            if (clr_w && cnt < 3) begin
                tws[cnt] = tw_w;
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("t3_cycles", cyc, 31);
        chk("t3_bins", cnt, 3);
        chk("t3_tw0", tws[0], 32'hFFFDF3B6);
        chk("t3_tw1", tws[1], 32'd0);
        chk("t3_tw2", tws[2], 32'd134218);

        // Asynchronous reset mid-sweep
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (24) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_clr", corr_clr, 0);
        chk("rst_mid_prn", prn, 3);
        chk("rst_mid_tw", doppler_tw, CTR);
        chk("rst_mid_best_mag", best_mag, 0);
        chk("rst_mid_found", found, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
